// File: rtl/psum_accumulator_pkg.sv
// Shared defaults, FSM encoding and saturation helper for the partial-sum accumulator.
package psum_accumulator_pkg;

    localparam int DEF_MAC_OUTPUT_WIDTH = 36;
    localparam int DEF_LANES            = 8;
    localparam int DEF_BUF_LATENCY      = 3;
    localparam int DEF_LEN_WIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Saturation bound for a signed lane of width w, returned zero/one-extended
    // to 64 bits; callers keep the low w bits.
    function automatic logic [63:0] sat_bound(input int w, input logic neg);
        logic [63:0] one;
        one = 64'd1 << (w - 1);
        return neg ? ~(one - 64'd1) : (one - 64'd1);
    endfunction

    // Saturation bounds of one lane at the default width.
    localparam logic [63:0] SAT_MAX = sat_bound(DEF_MAC_OUTPUT_WIDTH, 1'b0);
    localparam logic [63:0] SAT_MIN = sat_bound(DEF_MAC_OUTPUT_WIDTH, 1'b1);

endpackage

// File: rtl/psum_sat_add.sv
// Lane-wise saturating adder: mac + (first ? 0 : buf_data), registered and
// steered either to the buffer write-back port or to the final output port.
module psum_sat_add
    import psum_accumulator_pkg::*;
#(
    parameter int W     = DEF_MAC_OUTPUT_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               first,
    input  logic               last,
    input  logic [LANES*W-1:0] mac,
    input  logic [LANES*W-1:0] buf_data,
    output logic [LANES*W-1:0] feature_in,
    output logic               feature_valid,
    output logic [LANES*W-1:0] out_data,
    output logic               out_valid
);

    // At the default width these equal SAT_MAX / SAT_MIN.
    localparam logic [63:0]  MAX64    = sat_bound(W, 1'b0);
    localparam logic [63:0]  MIN64    = sat_bound(W, 1'b1);
    localparam logic [W-1:0] LANE_MAX = MAX64[W-1:0];
    localparam logic [W-1:0] LANE_MIN = MIN64[W-1:0];

    logic [LANES-1:0][W-1:0] sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W:0] a_ext, b_ext, sum_ext;
        // One guard bit is enough: the two top bits disagree only on overflow.
        assign a_ext   = {mac[k*W+W-1], mac[k*W +: W]};
        assign b_ext   = first ? '0 : {buf_data[k*W+W-1], buf_data[k*W +: W]};
        assign sum_ext = a_ext + b_ext;
        assign sat[k]  = (sum_ext[W:W-1] == 2'b01) ? LANE_MAX :
                         (sum_ext[W:W-1] == 2'b10) ? LANE_MIN :
                         sum_ext[W-1:0];
    end

    // Register the sum into the selected destination; the other bus holds.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            feature_in    <= '0;
            feature_valid <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
        end else begin
            feature_valid <= en & ~last;
            out_valid     <= en & last;
            if (en && !last) feature_in <= sat;
            if (en && last)  out_data   <= sat;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Read-modify-write controller for the output partial-sum buffer: accepts a
// pass of MAC vectors, reads the prior partial sums, and writes back (or
// emits on the final pass) the saturated lane-wise sums.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int MAC_OUTPUT_WIDTH = DEF_MAC_OUTPUT_WIDTH,
    parameter int LANES            = DEF_LANES,
    parameter int BUF_LATENCY      = DEF_BUF_LATENCY,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH
) (
    input  logic                              system_clk,
    input  logic                              rst_n,
    input  logic                              pass_start,
    input  logic [LEN_WIDTH-1:0]              pass_len,
    input  logic                              first_pass,
    input  logic                              last_pass,
    input  logic [LANES*MAC_OUTPUT_WIDTH-1:0] mac_data,
    input  logic                              mac_valid,
    output logic                              mac_ready,
    output logic                              refresh_req,
    output logic                              adder_pulse,
    input  logic [LANES*MAC_OUTPUT_WIDTH-1:0] adder_feature,
    output logic [LANES*MAC_OUTPUT_WIDTH-1:0] feature_in,
    output logic                              feature_valid,
    output logic [LANES*MAC_OUTPUT_WIDTH-1:0] out_data,
    output logic                              out_valid,
    output logic                              pass_done,
    output logic                              busy
);

    localparam int VW = LANES * MAC_OUTPUT_WIDTH;

    state_t                  state_q;
    logic [LEN_WIDTH-1:0]    len_q, count_q, count_nxt;
    logic                    first_q, last_q;
    logic                    accept;
    logic [BUF_LATENCY:1]    vld_pipe;
    logic [BUF_LATENCY:1][VW-1:0] dly_data;

    assign mac_ready   = (state_q == RUN) && (count_q < len_q);
    assign accept      = mac_valid & mac_ready;
    // The buffer read is issued with the accept so its data lands BUF_LATENCY
    // cycles later, exactly when the vector leaves the delay line.
    assign adder_pulse = accept & ~first_q;
    assign busy        = (state_q != IDLE);
    assign count_nxt   = count_q + LEN_WIDTH'(1);

    // Pass control: latch pass config, refresh pointers, count accepts, drain.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            refresh_req <= 1'b0;
            pass_done   <= 1'b0;
        end else begin
            refresh_req <= 1'b0;
            pass_done   <= 1'b0;
            case (state_q)
                IDLE: if (pass_start) begin
                    len_q       <= pass_len;
                    first_q     <= first_pass;
                    last_q      <= last_pass;
                    count_q     <= '0;
                    refresh_req <= 1'b1;
                    state_q     <= START;
                end
                START: state_q <= (len_q == '0) ? DRAIN : RUN;
                RUN: if (accept) begin
                    count_q <= count_nxt;
                    if (count_nxt == len_q) state_q <= DRAIN;
                end
                DRAIN: if (vld_pipe == '0 && !feature_valid && !out_valid) begin
                    pass_done <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Delay line matching the buffer read latency; data shifts freely, the
    // valid bits mark which slots carry accepted vectors.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dly_data <= '0;
        end else begin
            vld_pipe[1] <= accept;
            dly_data[1] <= mac_data;
            for (int i = 2; i <= BUF_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dly_data[i] <= dly_data[i-1];
            end
        end
    end

    psum_sat_add #(
        .W     (MAC_OUTPUT_WIDTH),
        .LANES (LANES)
    ) u_sat_add (
        .system_clk    (system_clk),
        .rst_n         (rst_n),
        .en            (vld_pipe[BUF_LATENCY]),
        .first         (first_q),
        .last          (last_q),
        .mac           (dly_data[BUF_LATENCY]),
        .buf_data      (adder_feature),
        .feature_in    (feature_in),
        .feature_valid (feature_valid),
        .out_data      (out_data),
        .out_valid     (out_valid)
    );

endmodule
